// File: rtl/map_mem_pkg.sv
// Shared types for the mapper-to-memory arbiter: region tags, FSM states and
// the per-port request slot captured on a strobe edge.
package map_mem_pkg;

  // Slot addresses are stored at a fixed width; ADDR_BITS must not exceed it.
  localparam int unsigned SLOT_ADDR_W = 32;
  localparam int unsigned DATA_W      = 8;

  typedef enum logic {
    REGION_PRG = 1'b0,
    REGION_CHR = 1'b1
  } region_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_PRG = 2'd1,
    SERVE_CHR = 2'd2
  } state_e;

  typedef struct packed {
    logic [SLOT_ADDR_W-1:0] addr;
    logic                   we;
    logic [DATA_W-1:0]      wdata;
  } slot_t;

  function automatic slot_t slot_capture(input logic [SLOT_ADDR_W-1:0] addr,
                                         input logic                   we,
                                         input logic [DATA_W-1:0]      wdata);
    slot_t s;
    s.addr  = addr;
    s.we    = we;
    s.wdata = wdata;
    return s;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, with a rising-edge pulse
// derived from the synchronized value.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_c
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_c  = sync_q & ~prev_q;

endmodule

// File: rtl/map_mem_arbiter.sv
// Turns mapper PRG/CHR bus strobes into single-beat requests on one shared
// memory port, CHR first, and returns read data to each bus side.
module map_mem_arbiter
  import map_mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 22
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] prg_addr,
  input  logic                 prg_oe,
  input  logic                 prg_we,
  input  logic [7:0]           cpu_data_in,
  input  logic [ADDR_BITS-1:0] chr_addr,
  input  logic                 chr_ce,
  input  logic                 chr_oe,
  input  logic                 chr_we,
  input  logic [7:0]           ppu_data_in,
  output logic [7:0]           prg_data_out,
  output logic [7:0]           chr_data_out,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS:0]   mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic                 mem_ack,
  input  logic [7:0]           mem_rdata,
  output logic                 overrun
);

  logic prg_oe_rise, prg_we_rise, chr_oe_rise, chr_we_rise;
  logic prg_oe_lvl, prg_we_lvl, chr_oe_lvl, chr_we_lvl;
  logic chr_ce_lvl, chr_ce_rise;
  logic unused_levels;

  sync_edge u_sync_prg_oe (.clk(clk), .rst(rst), .async_i(prg_oe), .level_o(prg_oe_lvl), .rise_c(prg_oe_rise));
  sync_edge u_sync_prg_we (.clk(clk), .rst(rst), .async_i(prg_we), .level_o(prg_we_lvl), .rise_c(prg_we_rise));
  sync_edge u_sync_chr_oe (.clk(clk), .rst(rst), .async_i(chr_oe), .level_o(chr_oe_lvl), .rise_c(chr_oe_rise));
  sync_edge u_sync_chr_we (.clk(clk), .rst(rst), .async_i(chr_we), .level_o(chr_we_lvl), .rise_c(chr_we_rise));
  sync_edge u_sync_chr_ce (.clk(clk), .rst(rst), .async_i(chr_ce), .level_o(chr_ce_lvl), .rise_c(chr_ce_rise));

  assign unused_levels = ^{prg_oe_lvl, prg_we_lvl, chr_oe_lvl, chr_we_lvl, chr_ce_rise};

  logic prg_edge_c;
  logic chr_edge_c;

  assign prg_edge_c = prg_oe_rise | prg_we_rise;
  assign chr_edge_c = chr_ce_lvl & (chr_oe_rise | chr_we_rise);

  state_e               state_q, state_d;
  slot_t                prg_slot_q, prg_slot_d;
  slot_t                chr_slot_q, chr_slot_d;
  logic                 prg_pend_q, prg_pend_d;
  logic                 chr_pend_q, chr_pend_d;
  logic                 prg_refresh_q, prg_refresh_d;
  logic                 chr_refresh_q, chr_refresh_d;
  logic                 overrun_q, overrun_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_BITS:0]   mem_addr_q, mem_addr_d;
  logic [7:0]           mem_wdata_q, mem_wdata_d;
  logic [7:0]           prg_data_q, prg_data_d;
  logic [7:0]           chr_data_q, chr_data_d;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      prg_slot_q    <= '0;
      chr_slot_q    <= '0;
      prg_pend_q    <= 1'b0;
      chr_pend_q    <= 1'b0;
      prg_refresh_q <= 1'b0;
      chr_refresh_q <= 1'b0;
      overrun_q     <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      prg_data_q    <= '0;
      chr_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      prg_slot_q    <= prg_slot_d;
      chr_slot_q    <= chr_slot_d;
      prg_pend_q    <= prg_pend_d;
      chr_pend_q    <= chr_pend_d;
      prg_refresh_q <= prg_refresh_d;
      chr_refresh_q <= chr_refresh_d;
      overrun_q     <= overrun_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      prg_data_q    <= prg_data_d;
      chr_data_q    <= chr_data_d;
    end
  end

  // Next-state: arbitration first, then edge capture so a new edge overrides a clear
  always_comb begin
    state_d       = state_q;
    prg_slot_d    = prg_slot_q;
    chr_slot_d    = chr_slot_q;
    prg_pend_d    = prg_pend_q;
    chr_pend_d    = chr_pend_q;
    prg_refresh_d = prg_refresh_q;
    chr_refresh_d = chr_refresh_q;
    overrun_d     = overrun_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    prg_data_d    = prg_data_q;
    chr_data_d    = chr_data_q;

    case (state_q)
      IDLE: begin
        if (chr_pend_q) begin
          state_d       = SERVE_CHR;
          mem_req_d     = 1'b1;
          mem_we_d      = chr_slot_q.we;
          mem_addr_d    = {1'(REGION_CHR), ADDR_BITS'(chr_slot_q.addr)};
          mem_wdata_d   = chr_slot_q.wdata;
          chr_refresh_d = 1'b0;
        end else if (prg_pend_q) begin
          state_d       = SERVE_PRG;
          mem_req_d     = 1'b1;
          mem_we_d      = prg_slot_q.we;
          mem_addr_d    = {1'(REGION_PRG), ADDR_BITS'(prg_slot_q.addr)};
          mem_wdata_d   = prg_slot_q.wdata;
          prg_refresh_d = 1'b0;
        end
      end
      SERVE_PRG: begin
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          prg_pend_d = prg_refresh_q;
          if (!mem_we_q) prg_data_d = mem_rdata;
        end
      end
      SERVE_CHR: begin
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          chr_pend_d = chr_refresh_q;
          if (!mem_we_q) chr_data_d = mem_rdata;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // A slot rewritten while its request is in flight must reissue after ack
    if (prg_edge_c) begin
      prg_slot_d = slot_capture(SLOT_ADDR_W'(prg_addr), prg_we_rise, cpu_data_in);
      prg_pend_d = 1'b1;
      if (prg_pend_q) overrun_d = 1'b1;
      if (state_d == SERVE_PRG) prg_refresh_d = 1'b1;
    end

    if (chr_edge_c) begin
      chr_slot_d = slot_capture(SLOT_ADDR_W'(chr_addr), chr_we_rise, ppu_data_in);
      chr_pend_d = 1'b1;
      if (chr_pend_q) overrun_d = 1'b1;
      if (state_d == SERVE_CHR) chr_refresh_d = 1'b1;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign prg_data_out = prg_data_q;
  assign chr_data_out = chr_data_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_map_mem_arbiter.sv
// Directed bench for map_mem_arbiter: reads, writes, CHR gating, priority,
// overrun and reset abandonment, with hand-computed expectations.
module tb_map_mem_arbiter;

  localparam int unsigned AB = 22;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AB-1:0] prg_addr = '0;
  logic          prg_oe = 1'b0;
  logic          prg_we = 1'b0;
  logic [7:0]    cpu_data_in = '0;
  logic [AB-1:0] chr_addr = '0;
  logic          chr_ce = 1'b0;
  logic          chr_oe = 1'b0;
  logic          chr_we = 1'b0;
  logic [7:0]    ppu_data_in = '0;
  logic [7:0]    prg_data_out;
  logic [7:0]    chr_data_out;
  logic          mem_req;
  logic          mem_we;
  logic [AB:0]   mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_ack = 1'b0;
  logic [7:0]    mem_rdata = '0;
  logic          overrun;

  int errors = 0;
  int checks = 0;

  map_mem_arbiter #(.ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst),
    .prg_addr(prg_addr), .prg_oe(prg_oe), .prg_we(prg_we), .cpu_data_in(cpu_data_in),
    .chr_addr(chr_addr), .chr_ce(chr_ce), .chr_oe(chr_oe), .chr_we(chr_we),
    .ppu_data_in(ppu_data_in),
    .prg_data_out(prg_data_out), .chr_data_out(chr_data_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) until mem_req is seen high at a falling edge
  task automatic wait_req(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_req) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  // One-cycle ack pulse; returns at the falling edge after it was sampled
  task automatic do_ack(input logic [7:0] rd);
    mem_ack   = 1'b1;
    mem_rdata = rd;
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},     32'(mem_req),      32'd0);
    check({tag, "_we"},      32'(mem_we),       32'd0);
    check({tag, "_addr"},    32'(mem_addr),     32'd0);
    check({tag, "_wdata"},   32'(mem_wdata),    32'd0);
    check({tag, "_prgdata"}, 32'(prg_data_out), 32'd0);
    check({tag, "_chrdata"}, 32'(chr_data_out), 32'd0);
    check({tag, "_overrun"}, 32'(overrun),      32'd0);
  endtask

  initial begin
    int req_seen;

    // Reset state
    tick(3);
    check_reset_values("rst0");
    rst = 1'b0;
    tick(2);
    check("idle_after_rst", 32'(mem_req), 32'd0);

    // PRG read: request appears exactly at the fourth edge after the strobe
    prg_addr = 22'h001234;
    prg_oe   = 1'b1;
    tick(3);
    check("prg_req_edge3", 32'(mem_req), 32'd0);
    tick(1);
    check("prg_req_edge4", 32'(mem_req), 32'd1);
    check("prg_addr", 32'(mem_addr), 32'h0001234);
    check("prg_we", 32'(mem_we), 32'd0);
    prg_oe = 1'b0;
    tick(2);
    check("prg_req_held", 32'(mem_req), 32'd1);
    do_ack(8'hA5);
    check("prg_req_drop", 32'(mem_req), 32'd0);
    check("prg_rdata", 32'(prg_data_out), 32'hA5);
    check("prg_chr_untouched", 32'(chr_data_out), 32'h00);

    // CHR write
    chr_ce = 1'b1;
    tick(4);
    chr_addr    = 22'h000ABC;
    ppu_data_in = 8'h5A;
    chr_we      = 1'b1;
    wait_req("chrw_req");
    chr_we = 1'b0;
    check("chrw_addr", 32'(mem_addr), 32'h0400ABC);
    check("chrw_we", 32'(mem_we), 32'd1);
    check("chrw_wdata", 32'(mem_wdata), 32'h5A);
    do_ack(8'hFF);
    check("chrw_req_drop", 32'(mem_req), 32'd0);
    check("chrw_data_keep", 32'(chr_data_out), 32'h00);
    check("chrw_prg_keep", 32'(prg_data_out), 32'hA5);

    // CHR gate: read strobe with chr_ce low never issues
    chr_ce = 1'b0;
    tick(4);
    chr_addr = 22'h000777;
    chr_oe   = 1'b1;
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 5) chr_oe = 1'b0;
      if (mem_req) req_seen++;
    end
    check("chr_gate_noreq", 32'(req_seen), 32'd0);
    chr_ce = 1'b1;
    tick(4);

    // Simultaneous reads: CHR first, PRG one idle cycle after CHR completes
    prg_addr = 22'h002222;
    chr_addr = 22'h000333;
    prg_oe   = 1'b1;
    chr_oe   = 1'b1;
    wait_req("simul_req1");
    check("simul_first_chr", 32'(mem_addr), 32'h0400333);
    prg_oe = 1'b0;
    chr_oe = 1'b0;
    tick(1);
    do_ack(8'h3C);
    check("simul_gap", 32'(mem_req), 32'd0);
    check("simul_chr_data", 32'(chr_data_out), 32'h3C);
    tick(1);
    check("simul_prg_req", 32'(mem_req), 32'd1);
    check("simul_prg_addr", 32'(mem_addr), 32'h0002222);
    do_ack(8'h7E);
    check("simul_prg_data", 32'(prg_data_out), 32'h7E);
    check("simul_chr_keep", 32'(chr_data_out), 32'h3C);

    // Overrun: second CHR strobe while the first is still unacknowledged
    tick(2);
    check("ovr_clear", 32'(overrun), 32'd0);
    chr_addr = 22'h000010;
    chr_oe   = 1'b1;
    wait_req("ovr_req1");
    check("ovr_addr1", 32'(mem_addr), 32'h0400010);
    chr_oe = 1'b0;
    tick(4);
    chr_addr = 22'h000020;
    chr_oe   = 1'b1;
    tick(5);
    chr_oe = 1'b0;
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_addr_stable", 32'(mem_addr), 32'h0400010);
    do_ack(8'h11);
    check("ovr_data1", 32'(chr_data_out), 32'h11);
    check("ovr_gap", 32'(mem_req), 32'd0);
    tick(1);
    check("ovr_req2", 32'(mem_req), 32'd1);
    check("ovr_addr2", 32'(mem_addr), 32'h0400020);
    do_ack(8'h22);
    check("ovr_data2", 32'(chr_data_out), 32'h22);
    tick(3);
    check("ovr_no_third", 32'(mem_req), 32'd0);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Reset mid-transaction
    prg_addr    = 22'h000055;
    cpu_data_in = 8'h66;
    prg_we      = 1'b1;
    wait_req("rstmid_req");
    check("rstmid_we", 32'(mem_we), 32'd1);
    #2;
    rst    = 1'b1;
    prg_we = 1'b0;
    #1;
    check_reset_values("rstmid");
    tick(2);
    rst = 1'b0;
    tick(1);
    do_ack(8'h99);
    check("late_ack_req", 32'(mem_req), 32'd0);
    check("late_ack_prg", 32'(prg_data_out), 32'h00);
    check("late_ack_chr", 32'(chr_data_out), 32'h00);
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req) req_seen++;
    end
    check("post_rst_quiet", 32'(req_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
